// File: rtl/w_74hc112_tester.sv
// w_74hc112_tester
//   Pin driver and checker for a W_74HC112 negative-edge JK flip-flop.
//   Walks a fixed 10-step truth-table sequence on S/R/J/K/CLK, samples the
//   synchronized Q/Qn at the end of each step and reports the outcome.
//
//   Parameters
//     DIV     system clocks per CLK_O half-phase (>= 1)
//     SETTLE  extra clocks after the drive phase before sampling (>= 0)
//
//   Ports
//     CLK        system clock, rising edge
//     R          asynchronous reset, active-low
//     START      run request, one-cycle pulse (ignored while BUSY)
//     S_O, R_O   DUT set / clear pins, active-low
//     CLK_O      DUT clock pin (capture on its falling edge)
//     J_O, K_O   DUT J / K pins
//     Q_I, Qn_I  DUT outputs, asynchronous to CLK
//     BUSY       sequence running
//     DONE       sequence finished, held until the next START
//     PASS       valid with DONE, 1 when no step mismatched
//     ERR_CNT    number of mismatching steps, saturating at 15
//     FAIL_STEP  index of the first failing step, 4'hF if none
module w_74hc112_tester #(
   parameter int unsigned DIV    = 4,
   parameter int unsigned SETTLE = 1
) (
   input  logic       CLK,
   input  logic       R,
   input  logic       START,
   output logic       S_O,
   output logic       R_O,
   output logic       CLK_O,
   output logic       J_O,
   output logic       K_O,
   input  logic       Q_I,
   input  logic       Qn_I,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [3:0] ERR_CNT,
   output logic [3:0] FAIL_STEP
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_FALL,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam logic [7:0] DIV_LAST    = 8'(DIV - 1);
   localparam logic [7:0] SAMPLE_LAST = 8'(SETTLE + 1);
   localparam logic [3:0] STEP_LAST   = 4'd9;

   state_t     state;
   state_t     state_next;
   logic [7:0] timer;
   logic [3:0] step;
   logic       q_s1, q_s2, qn_s1, qn_s2;

   logic       tbl_s, tbl_r, tbl_j, tbl_k, tbl_clk, tbl_exp;
   logic       launch;
   logic       sample_end;
   logic       mismatch;
   logic [3:0] err_next;

   // Step table: {S, R, J, K, clocked, expected Q}
   always_comb begin
      {tbl_s, tbl_r, tbl_j, tbl_k, tbl_clk, tbl_exp} = 6'b11_00_0_0;
      case (step)
         4'd0:    {tbl_s, tbl_r, tbl_j, tbl_k, tbl_clk, tbl_exp} = 6'b01_00_0_1;
         4'd1:    {tbl_s, tbl_r, tbl_j, tbl_k, tbl_clk, tbl_exp} = 6'b10_00_0_0;
         4'd2:    {tbl_s, tbl_r, tbl_j, tbl_k, tbl_clk, tbl_exp} = 6'b00_00_0_1;
         4'd3:    {tbl_s, tbl_r, tbl_j, tbl_k, tbl_clk, tbl_exp} = 6'b11_01_1_0;
         4'd4:    {tbl_s, tbl_r, tbl_j, tbl_k, tbl_clk, tbl_exp} = 6'b11_00_1_0;
         4'd5:    {tbl_s, tbl_r, tbl_j, tbl_k, tbl_clk, tbl_exp} = 6'b11_10_1_1;
         4'd6:    {tbl_s, tbl_r, tbl_j, tbl_k, tbl_clk, tbl_exp} = 6'b11_00_1_1;
         4'd7:    {tbl_s, tbl_r, tbl_j, tbl_k, tbl_clk, tbl_exp} = 6'b11_11_1_0;
         4'd8:    {tbl_s, tbl_r, tbl_j, tbl_k, tbl_clk, tbl_exp} = 6'b11_11_1_1;
         4'd9:    {tbl_s, tbl_r, tbl_j, tbl_k, tbl_clk, tbl_exp} = 6'b11_11_1_0;
         default: {tbl_s, tbl_r, tbl_j, tbl_k, tbl_clk, tbl_exp} = 6'b11_00_0_0;
      endcase
   end

   // Two-flop synchronizers for the asynchronous DUT outputs
   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         q_s1  <= 1'b0;
         q_s2  <= 1'b0;
         qn_s1 <= 1'b0;
         qn_s2 <= 1'b0;
      end else begin
         q_s1  <= Q_I;
         q_s2  <= q_s1;
         qn_s1 <= Qn_I;
         qn_s2 <= qn_s1;
      end
   end

   always_ff @(posedge CLK or negedge R) begin
      if (!R) state <= ST_IDLE;
      else    state <= state_next;
   end

   always_comb begin
      state_next = state;
      S_O        = 1'b1;
      R_O        = 1'b1;
      CLK_O      = 1'b1;
      J_O        = 1'b0;
      K_O        = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (START) state_next = ST_SETUP;
         end
         ST_SETUP: begin
            {S_O, R_O, J_O, K_O} = {tbl_s, tbl_r, tbl_j, tbl_k};
            if (timer == DIV_LAST) state_next = tbl_clk ? ST_FALL : ST_SAMPLE;
         end
         ST_FALL: begin
            {S_O, R_O, J_O, K_O} = {tbl_s, tbl_r, tbl_j, tbl_k};
            CLK_O = 1'b0;
            if (timer == DIV_LAST) state_next = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            // Clocked steps keep CLK_O low; it only rises in the next SETUP.
            {S_O, R_O, J_O, K_O} = {tbl_s, tbl_r, tbl_j, tbl_k};
            CLK_O = ~tbl_clk;
            if (timer == SAMPLE_LAST)
               state_next = (step == STEP_LAST) ? ST_DONE : ST_SETUP;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign launch     = ((state == ST_IDLE) || (state == ST_DONE)) && START;
   assign sample_end = (state == ST_SAMPLE) && (timer == SAMPLE_LAST);
   assign mismatch   = (q_s2 != tbl_exp) || (qn_s2 != ~tbl_exp);
   assign err_next   = (mismatch && (ERR_CNT != 4'hF)) ? ERR_CNT + 4'd1 : ERR_CNT;

   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         timer     <= '0;
         step      <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         PASS      <= 1'b0;
         ERR_CNT   <= '0;
         FAIL_STEP <= '1;
      end else begin
         // Every phase boundary is a state change, so the timer restarts there.
         timer <= (state_next != state) ? '0 : timer + 8'd1;
         if (launch) begin
            step      <= '0;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_CNT   <= '0;
            FAIL_STEP <= '1;
         end
         if (sample_end) begin
            ERR_CNT <= err_next;
            if (mismatch && (FAIL_STEP == 4'hF)) FAIL_STEP <= step;
            if (step == STEP_LAST) begin
               BUSY <= 1'b0;
               DONE <= 1'b1;
               PASS <= (err_next == 4'd0);
            end else begin
               step <= step + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_w_74hc112_tester.sv
// tb_w_74hc112_tester
//   Drives w_74hc112_tester against a behavioural negedge JK flip-flop with
//   selectable defects. Expected run outcomes are predicted from the step
//   table and JK rules, queued at START, and checked when DONE rises.
module tb_w_74hc112_tester;

   localparam int unsigned DIV        = 4;
   localparam int unsigned SETTLE     = 1;
   localparam int unsigned RUN_CYCLES = 3 * (DIV + SETTLE + 2) + 7 * (2 * DIV + SETTLE + 2);

   logic       CLK   = 1'b0;
   logic       R     = 1'b0;
   logic       START = 1'b0;
   logic       S_O, R_O, CLK_O, J_O, K_O;
   logic       Q_I, Qn_I;
   logic       BUSY, DONE, PASS;
   logic [3:0] ERR_CNT, FAIL_STEP;

   w_74hc112_tester #(.DIV(DIV), .SETTLE(SETTLE)) dut (
      .CLK(CLK), .R(R), .START(START),
      .S_O(S_O), .R_O(R_O), .CLK_O(CLK_O), .J_O(J_O), .K_O(K_O),
      .Q_I(Q_I), .Qn_I(Qn_I),
      .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
      .ERR_CNT(ERR_CNT), .FAIL_STEP(FAIL_STEP)
   );

   always #5 CLK = ~CLK;

   int unsigned cyc = 0;
   always @(posedge CLK) cyc++;

   int nchecks = 0;
   int nerrors = 0;

   // Flip-flop under test: ideal, Q stuck at 0, J=K=1 holds, Qn tied to Q
   typedef enum int {M_IDEAL, M_STUCK0, M_HOLD, M_QNTIED} mode_t;
   mode_t mode = M_IDEAL;
   logic  ff_q = 1'b0;

   always @(negedge CLK_O or negedge S_O or negedge R_O) begin
      if (!S_O)      ff_q <= 1'b1;
      else if (!R_O) ff_q <= 1'b0;
      else begin
         case ({J_O, K_O})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= (mode == M_HOLD) ? ff_q : ~ff_q;
            default: ff_q <= ff_q;
         endcase
      end
   end

   assign Q_I  = (mode == M_STUCK0) ? 1'b0 : ff_q;
   assign Qn_I = (mode == M_QNTIED) ? Q_I : ~Q_I;

   // Truth-table sequence as the lab sheet lists it
   bit s_tab [10] = '{0, 1, 0, 1, 1, 1, 1, 1, 1, 1};
   bit r_tab [10] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
   bit j_tab [10] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 1};
   bit k_tab [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1};
   bit c_tab [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
   bit e_tab [10] = '{1, 0, 1, 0, 0, 1, 1, 0, 1, 0};

   typedef struct {
      int unsigned err;
      int unsigned fail_step;
      int unsigned pass;
      int unsigned start_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   function automatic exp_t predict(mode_t m, int unsigned sc);
      exp_t r;
      bit   q, oq, oqn;
      q = 1'b0;
      r.err = 0;
      r.fail_step = 15;
      r.start_cyc = sc;
      for (int i = 0; i < 10; i++) begin
         if (!c_tab[i]) q = !s_tab[i] ? 1'b1 : 1'b0;
         else if (j_tab[i] && k_tab[i]) q = (m == M_HOLD) ? q : !q;
         else if (j_tab[i]) q = 1'b1;
         else if (k_tab[i]) q = 1'b0;
         oq  = (m == M_STUCK0) ? 1'b0 : q;
         oqn = (m == M_QNTIED) ? oq : !oq;
         if (oq != e_tab[i] || oqn == e_tab[i]) begin
            if (r.err < 15) r.err++;
            if (r.fail_step == 15) r.fail_step = i;
         end
      end
      r.pass = (r.err == 0) ? 1 : 0;
      return r;
   endfunction

   task automatic check(string name, int unsigned act, int unsigned req);
      nchecks++;
      if (act != req) begin
         nerrors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_reset_vals(string tag);
      check({tag, "_pins"}, {S_O, R_O, CLK_O, J_O, K_O}, 5'b11100);
      check({tag, "_busy"}, BUSY, 0);
      check({tag, "_done"}, DONE, 0);
      check({tag, "_pass"}, PASS, 0);
      check({tag, "_err_cnt"}, ERR_CNT, 0);
      check({tag, "_fail_step"}, FAIL_STEP, 15);
   endtask

   // Monitor: every rising DONE consumes one predicted run
   logic done_d = 1'b0;
   always @(negedge CLK) begin
      if (DONE && !done_d) begin
         if (sb.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL unexpected_done: got DONE=1, expected no run pending (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            check("err_cnt", ERR_CNT, mon_e.err);
            check("fail_step", FAIL_STEP, mon_e.fail_step);
            check("pass", PASS, mon_e.pass);
            check("busy_at_done", BUSY, 0);
            check("run_latency", cyc - mon_e.start_cyc, RUN_CYCLES);
            check("done_pins", {S_O, R_O, CLK_O, J_O, K_O}, 5'b11100);
         end
      end
      done_d = DONE;
   end

   task automatic issue_start(bit expect_run);
      @(negedge CLK);
      START = 1'b1;
      if (expect_run) sb.push_back(predict(mode, cyc + 1));
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic wait_sb_empty(int unsigned limit);
      int unsigned n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(negedge CLK);
         n++;
      end
      if (sb.size() != 0) begin
         nchecks++;
         nerrors++;
         $display("FAIL done_timeout: got no DONE in %0d cycles, expected DONE within %0d", limit, RUN_CYCLES);
         sb.delete();
      end
      repeat (2) @(negedge CLK);
   endtask

   task automatic mid_run_starts(int unsigned count);
      for (int unsigned i = 0; i < count; i++) begin
         repeat ($urandom_range(2, 25)) @(negedge CLK);
         issue_start(1'b0);
      end
   endtask

   initial begin
      R = 1'b0;
      repeat (3) @(negedge CLK);
      check_reset_vals("reset");
      R = 1'b1;

      // Ideal flip-flop
      mode = M_IDEAL;
      issue_start(1'b1);
      check("busy_after_start", BUSY, 1);
      wait_sb_empty(RUN_CYCLES + 20);

      // Restart from DONE with Q stuck low
      mode = M_STUCK0;
      issue_start(1'b1);
      check("restart_done_clr", DONE, 0);
      check("restart_pass_clr", PASS, 0);
      check("restart_busy", BUSY, 1);
      wait_sb_empty(RUN_CYCLES + 20);

      // Toggle holds; extra STARTs during the run must be ignored
      mode = M_HOLD;
      issue_start(1'b1);
      mid_run_starts(3);
      wait_sb_empty(RUN_CYCLES + 20);

      // Qn tied to Q
      mode = M_QNTIED;
      issue_start(1'b1);
      wait_sb_empty(RUN_CYCLES + 20);

      // Reset during the FALL phase of step 5
      mode = M_IDEAL;
      issue_start(1'b1);
      repeat (48) @(negedge CLK);
      check("step5_fall_clk", CLK_O, 0);
      #2;
      R = 1'b0;
      sb.delete();
      #1;
      check_reset_vals("async_reset");
      @(negedge CLK);
      R = 1'b1;
      issue_start(1'b1);
      wait_sb_empty(RUN_CYCLES + 20);

      // Randomized runs
      repeat (5) begin
         mode = mode_t'($urandom_range(0, 3));
         repeat ($urandom_range(0, 6)) @(negedge CLK);
         issue_start(1'b1);
         mid_run_starts($urandom_range(0, 2));
         wait_sb_empty(RUN_CYCLES + 20);
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
